// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - MEM-stage store buffer: lane/enable generation, FIFO drain to data memory, load-after-store hazard
module mem_store_buffer #(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [1:0]               in_op,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     flush,
  output logic                     in_ready,
  output logic                     misalign,
  input  logic                     ld_check,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hazard,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic [3:0]               mem_wea,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-3:0]   addr_q [DEPTH];
  logic [DW-1:0]   data_q [DEPTH];
  logic [3:0]      wea_q  [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [3:0]      lane_wea;
  logic [DW-1:0]   lane_wdata;
  logic            lane_mis;
  logic            push, pop, hit;
  logic [1:0]      unused_ld_offset;

  assign unused_ld_offset = ld_addr[1:0];

  // Data is replicated across lanes so the enables alone select the written bytes.
  always_comb begin
    lane_wea   = 4'b0000;
    lane_wdata = '0;
    lane_mis   = 1'b0;
    case (in_op)
      2'b01: begin
        lane_wea   = 4'b0001 << in_addr[1:0];
        lane_wdata = {4{in_data[7:0]}};
      end
      2'b10: begin
        lane_wea   = in_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{in_data[15:0]}};
        lane_mis   = in_addr[0];
      end
      2'b11: begin
        lane_wea   = 4'b1111;
        lane_wdata = in_data;
        lane_mis   = (in_addr[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

  assign in_ready = (count_q < FULL);
  assign misalign = in_valid & ~flush & (in_op != 2'b00) & lane_mis;
  assign push     = in_valid & (in_op != 2'b00) & ~flush & ~lane_mis & in_ready;
  assign mem_req  = valid_q[rd_ptr_q];
  assign pop      = mem_req & mem_ack;

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= in_addr[AW-1:2];
      data_q[wr_ptr_q] <= lane_wdata;
      wea_q[wr_ptr_q]  <= lane_wea;
    end
  end

  // The head stays visible to the hazard check during its own ack cycle.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == ld_addr[AW-1:2])) hit = 1'b1;
    end
  end

  assign ld_hazard = ld_check & hit;
  assign mem_addr  = mem_req ? {addr_q[rd_ptr_q], 2'b00} : '0;
  assign mem_wdata = mem_req ? data_q[rd_ptr_q] : '0;
  assign mem_wea   = mem_req ? wea_q[rd_ptr_q] : 4'b0000;
  assign count     = count_q;

endmodule

// File: tb/tb_mem_store_buffer.sv
// tb/tb_mem_store_buffer.sv - self-checking bench for mem_store_buffer against a queue-based store model
module tb_mem_store_buffer;
  localparam int DEPTH = 2;

  logic        clk, reset, in_valid, flush, ld_check, mem_ack;
  logic [1:0]  in_op;
  logic [31:0] in_addr, in_data, ld_addr;
  logic        in_ready, misalign, ld_hazard, mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wea;
  logic [1:0]  count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  we;
  } ent_t;
  ent_t mq[$];

  mem_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
    .in_data(in_data), .flush(flush), .in_ready(in_ready), .misalign(misalign),
    .ld_check(ld_check), .ld_addr(ld_addr), .ld_hazard(ld_hazard), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wea(mem_wea), .mem_ack(mem_ack),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_mis(logic [1:0] op, logic [31:0] a);
    if (op == 2'd2) return (a % 2) != 0;
    if (op == 2'd3) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_wea(logic [1:0] op, logic [31:0] a);
    case (op)
      2'd1: return 4'(1 << (a % 4));
      2'd2: return ((a % 4) >= 2) ? 4'hC : 4'h3;
      2'd3: return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(logic [1:0] op, logic [31:0] d);
    case (op)
      2'd1: return (d & 32'hFF) * 32'h01010101;
      2'd2: return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic bit m_hazard(logic chk, logic [31:0] la);
    bit h = 1'b0;
    foreach (mq[i]) if (mq[i].wa == (la >> 2)) h = 1'b1;
    return chk && h;
  endfunction

  task automatic idle();
    in_valid = 0; in_op = 0; in_addr = 0; in_data = 0; flush = 0;
    ld_check = 0; ld_addr = 0; mem_ack = 0;
  endtask

  task automatic drive_st(logic [1:0] op, logic [31:0] a, logic [31:0] d);
    in_valid = 1; in_op = op; in_addr = a; in_data = d;
  endtask

  // Advance one clock and apply the store-buffer rules to the model.
  task automatic tick();
    bit   do_push, do_pop;
    ent_t e;
    do_push = in_valid && in_op != 0 && !flush && !m_mis(in_op, in_addr) && mq.size() < DEPTH;
    do_pop  = mq.size() > 0 && mem_ack;
    e.wa = in_addr >> 2;
    e.wd = m_wdata(in_op, in_data);
    e.we = m_wea(in_op, in_addr);
    @(posedge clk);
    if (reset) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1; tick(); tick(); reset = 0; #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %0h want 1", in_ready); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got %0h want 0", mem_req); end
    n_vec++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wea !== 4'h0)
      begin n_err++; $display("FAIL rst_head got %h/%h/%h want 0/0/0", mem_addr, mem_wdata, mem_wea); end
    n_vec++; if (count !== 2'd0 || misalign !== 1'b0 || ld_hazard !== 1'b0)
      begin n_err++; $display("FAIL rst_flags got cnt=%0d mis=%0h haz=%0h want 0", count, misalign, ld_hazard); end
  endtask

  task automatic test_sw_basic();
    idle(); drive_st(2'd3, 32'h100, 32'hDEADBEEF); tick(); idle();
    n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h100)
      begin n_err++; $display("FAIL sw_req got req=%0h addr=%h want 1/00000100", mem_req, mem_addr); end
    n_vec++; if (mem_wea !== 4'hF || mem_wdata !== 32'hDEADBEEF)
      begin n_err++; $display("FAIL sw_lane got wea=%h data=%h want f/deadbeef", mem_wea, mem_wdata); end
    mem_ack = 1; tick(); idle();
    n_vec++; if (mem_req !== 1'b0 || count !== 2'd0)
      begin n_err++; $display("FAIL sw_drain got req=%0h cnt=%0d want 0/0", mem_req, count); end
  endtask

  task automatic test_lanes();
    idle(); drive_st(2'd1, 32'h203, 32'h000000AB); tick(); idle();
    n_vec++; if (mem_wea !== 4'h8 || mem_wdata !== 32'hABABABAB || mem_addr !== 32'h200)
      begin n_err++; $display("FAIL sb_lane got wea=%h data=%h addr=%h want 8/ababab ab/200", mem_wea, mem_wdata, mem_addr); end
    mem_ack = 1; tick(); idle();
    drive_st(2'd2, 32'h302, 32'h00001234); tick(); idle();
    n_vec++; if (mem_wea !== 4'hC || mem_wdata !== 32'h12341234 || mem_addr !== 32'h300)
      begin n_err++; $display("FAIL sh_lane got wea=%h data=%h addr=%h want c/12341234/300", mem_wea, mem_wdata, mem_addr); end
    mem_ack = 1; tick(); idle();
  endtask

  task automatic test_misalign();
    idle(); drive_st(2'd2, 32'h101, 32'h5555); #1;
    n_vec++; if (misalign !== 1'b1) begin n_err++; $display("FAIL mis_sh got %0h want 1", misalign); end
    tick(); drive_st(2'd3, 32'h102, 32'h77777777); #1;
    n_vec++; if (misalign !== 1'b1) begin n_err++; $display("FAIL mis_sw got %0h want 1", misalign); end
    tick(); idle();
    n_vec++; if (count !== 2'd0 || mem_req !== 1'b0)
      begin n_err++; $display("FAIL mis_noenq got cnt=%0d req=%0h want 0/0", count, mem_req); end
    drive_st(2'd3, 32'h102, 32'h77777777); flush = 1; #1;
    n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL mis_flush got %0h want 0", misalign); end
    tick(); idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d[3];
    idle();
    for (int i = 0; i < 3; i++) begin
      d[i] = $urandom;
      drive_st(2'd3, 32'h500 + 32'(4 * i), d[i]); tick();
    end
    idle();
    n_vec++; if (count !== 2'd2 || in_ready !== 1'b0)
      begin n_err++; $display("FAIL full_cnt got cnt=%0d rdy=%0h want 2/0", count, in_ready); end
    tick();
    n_vec++; if (mem_addr !== 32'h500 || mem_wdata !== d[0] || mem_req !== 1'b1)
      begin n_err++; $display("FAIL full_stable got addr=%h data=%h want 00000500/%h", mem_addr, mem_wdata, d[0]); end
    mem_ack = 1; tick();
    n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h504 || mem_wdata !== d[1] || count !== 2'd1)
      begin n_err++; $display("FAIL b2b_second got req=%0h addr=%h data=%h cnt=%0d want 1/504/%h/1", mem_req, mem_addr, mem_wdata, count, d[1]); end
    tick(); idle();
    n_vec++; if (mem_req !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1)
      begin n_err++; $display("FAIL b2b_empty got req=%0h cnt=%0d rdy=%0h want 0/0/1", mem_req, count, in_ready); end
  endtask

  task automatic test_hazard();
    idle(); drive_st(2'd3, 32'h400, 32'h11223344); tick(); idle();
    ld_check = 1; ld_addr = 32'h402; #1;
    n_vec++; if (ld_hazard !== 1'b1) begin n_err++; $display("FAIL haz_hit got %0h want 1", ld_hazard); end
    ld_addr = 32'h404; #1;
    n_vec++; if (ld_hazard !== 1'b0) begin n_err++; $display("FAIL haz_miss got %0h want 0", ld_hazard); end
    ld_addr = 32'h400; mem_ack = 1; #1;
    n_vec++; if (ld_hazard !== 1'b1) begin n_err++; $display("FAIL haz_ackcyc got %0h want 1", ld_hazard); end
    tick(); mem_ack = 0; ld_addr = 32'h402; #1;
    n_vec++; if (ld_hazard !== 1'b0) begin n_err++; $display("FAIL haz_drained got %0h want 0", ld_hazard); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    drive_st(2'd3, 32'h600, 32'hA5A5A5A5); tick();
    drive_st(2'd1, 32'h605, 32'h0000003C); tick(); idle();
    reset = 1; tick(); reset = 0; #1;
    n_vec++; if (mem_req !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1)
      begin n_err++; $display("FAIL rstmid got req=%0h cnt=%0d rdy=%0h want 0/0/1", mem_req, count, in_ready); end
    drive_st(2'd3, 32'h700, 32'h12345678); flush = 1; tick(); idle();
    n_vec++; if (mem_req !== 1'b0 || count !== 2'd0)
      begin n_err++; $display("FAIL flush_noenq got req=%0h cnt=%0d want 0/0", mem_req, count); end
  endtask

  task automatic test_random();
    logic [31:0] ea, ed;
    logic [3:0]  ew;
    for (int c = 0; c < 400; c++) begin
      reset    = ($urandom_range(0, 79) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      in_op    = 2'($urandom_range(0, 3));
      in_addr  = 32'h1000 + $urandom_range(0, 23);
      in_data  = $urandom;
      flush    = ($urandom_range(0, 7) == 0);
      mem_ack  = $urandom_range(0, 2) == 0;
      ld_check = $urandom_range(0, 1);
      ld_addr  = 32'h1000 + $urandom_range(0, 23);
      #1;
      ea = (mq.size() > 0) ? (mq[0].wa << 2) : 32'h0;
      ed = (mq.size() > 0) ? mq[0].wd : 32'h0;
      ew = (mq.size() > 0) ? mq[0].we : 4'h0;
      n_vec++; if (misalign !== (in_valid && !flush && in_op != 0 && m_mis(in_op, in_addr)))
        begin n_err++; $display("FAIL rnd_mis c=%0d got %0h", c, misalign); end
      n_vec++; if (ld_hazard !== m_hazard(ld_check, ld_addr))
        begin n_err++; $display("FAIL rnd_haz c=%0d got %0h want %0h", c, ld_hazard, m_hazard(ld_check, ld_addr)); end
      n_vec++; if (count !== 2'(mq.size()) || in_ready !== (mq.size() < DEPTH) || mem_req !== (mq.size() > 0))
        begin n_err++; $display("FAIL rnd_occ c=%0d got cnt=%0d rdy=%0h req=%0h want cnt=%0d", c, count, in_ready, mem_req, mq.size()); end
      n_vec++; if (mem_addr !== ea || mem_wdata !== ed || mem_wea !== ew)
        begin n_err++; $display("FAIL rnd_head c=%0d got %h/%h/%h want %h/%h/%h", c, mem_addr, mem_wdata, mem_wea, ea, ed, ew); end
      tick();
    end
    reset = 0; idle();
  endtask

  initial begin
    reset = 1; idle();
    test_reset();
    test_sw_basic();
    test_lanes();
    test_misalign();
    test_back_to_back();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
